// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, types and lane helpers for the 16-point radix-4 FFT datapath
package fft_pkg;
  localparam int DW = 17;
  localparam int NPT = 16;
  localparam int LANES = 4;
  localparam int CW = 2 * DW;
  localparam int LANE_STEP = NPT / LANES;
  typedef logic [CW-1:0] cplx_t;
  typedef logic [LANES*CW-1:0] word_t;
  typedef enum logic {IDLE, DRAIN} rd_state_t;
  function automatic logic [DW-1:0] re_of(cplx_t c);
    return c[CW-1:DW];
  endfunction
  function automatic logic [DW-1:0] im_of(cplx_t c);
    return c[DW-1:0];
  endfunction
  function automatic cplx_t lane_of(word_t w, logic [1:0] j);
    return w[j*CW +: CW];
  endfunction
endpackage

// File: rtl/s_p_if.sv
// s_p_if: sample stream in, butterfly-word stream out of the serial-to-parallel stage
interface s_p_if;
  import fft_pkg::*;
  cplx_t data_in_1;
  logic in_valid;
  logic in_sop;
  word_t data_out_1;
  logic s_p_flag_out;
  logic out_sop;
  logic sop_err;
  modport master (output data_in_1, in_valid, in_sop, input data_out_1, s_p_flag_out, out_sop, sop_err);
  modport slave (input data_in_1, in_valid, in_sop, output data_out_1, s_p_flag_out, out_sop, sop_err);
endinterface

// File: rtl/sp_bank.sv
// sp_bank: 16-entry sample bank with a 4-lane read port, lane j returning x[k + 4j]
module sp_bank
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  cplx_t      wdata,
  input  logic [1:0] k,
  output word_t      rdata
);
  cplx_t mem [NPT];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign rdata[j*CW +: CW] = mem[4'(j*LANE_STEP) + {2'b00, k}];
  end
endmodule

// File: rtl/s_p.sv
// s_p: ping-pong collects 16-sample frames and drains each as four radix-4 butterfly words
module s_p
  import fft_pkg::*;
(
  input logic clk,
  input logic rst,
  s_p_if.slave io
);
  logic [3:0] wr_cnt, waddr;
  logic [1:0] rd_cnt;
  logic wr_bank, rd_bank, done, abort;
  rd_state_t st;
  word_t rd0, rd1;
  // an in_sop always restarts at index 0, discarding whatever partial frame was in progress
  assign waddr = io.in_sop ? 4'd0 : wr_cnt;
  assign done = io.in_valid && waddr == 4'(NPT - 1);
  assign abort = io.in_valid && io.in_sop && wr_cnt != 4'd0;
  sp_bank u_b0 (.clk(clk), .we(io.in_valid && !wr_bank), .waddr(waddr), .wdata(io.data_in_1), .k(rd_cnt), .rdata(rd0));
  sp_bank u_b1 (.clk(clk), .we(io.in_valid && wr_bank), .waddr(waddr), .wdata(io.data_in_1), .k(rd_cnt), .rdata(rd1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_cnt <= '0;
      st <= IDLE;
      io.data_out_1 <= '0;
      io.s_p_flag_out <= 1'b1;
      io.out_sop <= 1'b0;
      io.sop_err <= 1'b0;
    end else begin
      io.sop_err <= abort;
      if (io.in_valid) wr_cnt <= waddr + 4'd1;
      if (done) begin
        wr_bank <= !wr_bank;
        rd_bank <= wr_bank;
      end
      if (st == DRAIN) begin
        io.data_out_1 <= rd_bank ? rd1 : rd0;
        io.s_p_flag_out <= 1'b0;
        io.out_sop <= rd_cnt == 2'd0;
        rd_cnt <= rd_cnt + 2'd1;
        st <= rd_cnt == 2'd3 ? IDLE : DRAIN;
      end else begin
        io.s_p_flag_out <= 1'b1;
        io.out_sop <= 1'b0;
        rd_cnt <= '0;
        st <= done ? DRAIN : IDLE;
      end
    end
endmodule

// File: doc/s_p.md
Name: s_p

Overview:
- Serial-to-parallel input stage of the 16-point radix-4 FFT datapath.
- Accepts one complex sample per cycle (34 bits: real in [33:17], imag in [16:0]) and collects one 16-sample frame.
- Once the frame is complete, emits it as four 136-bit words, one word per radix-4 first-stage butterfly.
- Ping-pong buffered, so input can stream continuously at one sample per clock with no back-pressure.

Parameters:
- DW, 17: width of one real or imaginary component (two's complement).
- NPT, 16: points per frame; fixed to 16, not for override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in_1  input  2*DW  complex sample; real in [2DW-1:DW], imag in [DW-1:0].
- in_valid  input  1  data_in_1 is accepted on a rising edge where in_valid=1.
- in_sop  input  1  qualified by in_valid; marks sample 0 of a frame.
- data_out_1  output  8*DW  four complex lanes; lane j occupies [(j+1)*2DW-1 : j*2DW].
- s_p_flag_out  output  1  active-low: 0 while data_out_1 carries a valid word.
- out_sop  output  1  1 on the cycle word 0 of a frame is presented.
- sop_err  output  1  one-cycle pulse when a frame is aborted by an early in_sop.

Behaviour:
- Reset (asynchronous, any time, including mid-frame or mid-drain):
  - Partial and pending frames are discarded.
  - wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0.
  - data_out_1=0, s_p_flag_out=1, out_sop=0, sop_err=0.
- Storage: two banks of 16 x 2DW registers.
  - Write side owns wr_bank; read side owns rd_bank.
- Write side: on in_valid=1, store data_in_1 at bank[wr_bank][wr_cnt], then wr_cnt++ (4-bit).
  - in_valid gaps are allowed; wr_cnt and bank contents hold while in_valid=0.
- in_sop with in_valid and wr_cnt==0: normal frame start.
- in_sop with in_valid and wr_cnt!=0: abort the partial frame.
  - The sample is written at index 0 and wr_cnt becomes 1.
  - sop_err=1 on the next cycle.
  - The aborted frame is never output.
- in_sop is not required; a frame is simply every 16 accepted samples.
- Frame complete (sample index 15 accepted at edge E):
  - rd_bank<=wr_bank, wr_bank toggles, wr_cnt wraps to 0, rd_active<=1, rd_cnt<=0.
- Read FSM has two states.
  - IDLE (rd_active=0).
  - DRAIN: on each edge emit word rd_cnt, rd_cnt++. After word 3, return to IDLE.
- Output word k (k=0..3) = {x[k+12], x[k+8], x[k+4], x[k]}, with lane 0 (LSBs) = x[k].
- Timing: word 0 is registered at edge E+1, word 3 at edge E+4.
  - s_p_flag_out=0 for exactly those 4 consecutive cycles.
  - out_sop=1 with word 0 only.
- Outside DRAIN: s_p_flag_out=1, out_sop=0, and data_out_1 holds the last emitted word.
- Overlap: refilling the drained bank takes at least 16 cycles and draining takes 4. Completion therefore never collides with an active drain, and no stall logic is required.
  - Verification must assert that completion never occurs while rd_active=1.
- Back-to-back frames at full rate: a new 4-cycle burst every 16 cycles, spaced 12 idle cycles apart.
- Data passes bit-exact; there is no arithmetic or rounding.

Decomposition:
- Shared package fft_pkg:
  - DW=17, NPT=16, LANES=4, CW=2*DW.
  - Lane-slice helper functions for real/imag extraction.
  - Lane-index constant used by both this block and its downstream parallel-to-serial stage.
- Sub-module sp_bank: one 16 x CW register bank.
  - Write port: we, waddr[3:0], wdata.
  - Combinational 4-lane read port selected by k[1:0].
  - s_p instantiates two banks; the top level holds wr/rd counters, bank select, the drain FSM and output registers.

Test Plan:
- Stimulus for the first three cases: reset release, then 16 samples with in_valid=1 continuous, in_sop on sample 0, data x[i]={real=i, imag=0x100+i}.
  - Expected word 0 = {x12,x8,x4,x0}, e.g. lane 0 real=0/imag=0x100 and lane 3 real=12/imag=0x10C.
  - Expected word 3 = {x15,x11,x7,x3}.
  - s_p_flag_out low for cycles E+1..E+4; out_sop high at E+1 only.
- Latency: same stimulus, check the registered timing exactly.
  - Word 0 is presented one cycle after sample 15 is captured.
  - data_out_1 holds word 3 after the burst.
- Back-to-back: 3 frames at full rate, frame f using real=16f+i.
  - Three bursts, each starting 16 cycles after the previous one.
  - Per-frame contents are correct, with no mixing between banks.
- Gapped input: in_valid toggled in a random pattern, about 50% duty, over one frame.
  - Output is identical to the continuous case; the burst starts one cycle after the 16th accepted sample.
- Early sop: 9 samples, then in_sop with a new frame of 16 samples.
  - sop_err pulses once.
  - Exactly one burst is produced, containing only the new frame.
- Reset mid-frame and mid-drain: assert rst after sample 7, and separately during word 1 of a burst.
  - Outputs go immediately to reset values.
  - A subsequent full frame is emitted correctly.
